// File: rtl/spi_wr_serializer.sv
// spi_wr_serializer
// Turns a flash page-program command plus its write-data beats into a byte
// stream for a QSPI shifter: opcode 0x02, three address bytes, then every
// data byte of every beat, byte 0 of each beat first. Bytes whose strobe is
// clear are sent as 0xFF so the flash cell is left unchanged. A command that
// is empty, too long, or would run past the end of a 256-byte page is not
// sent; its beats are swallowed and an error is reported on completion.
//
// Ports
//   aclk, areset          clock; synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; cmd_addr (only [23:0] used),
//                         cmd_beats = number of DW-bit beats (1..16 legal)
//   wdata/wstrb/wvalid/wready   write-data beats
//   tx_byte/tx_valid/tx_last/tx_ready   byte stream, tx_last on final byte
//   done_valid/done_err/done_ready      completion status
module spi_wr_serializer #(
  parameter int DW = 128,
  parameter int AW = 32
) (
  input  logic            aclk,
  input  logic            areset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [4:0]      cmd_beats,
  input  logic [DW-1:0]   wdata,
  input  logic [DW/8-1:0] wstrb,
  input  logic            wvalid,
  output logic            wready,
  output logic [7:0]      tx_byte,
  output logic            tx_valid,
  output logic            tx_last,
  input  logic            tx_ready,
  output logic            done_valid,
  output logic            done_err,
  input  logic            done_ready
);
  localparam int NB  = DW / 8;
  localparam int BIW = $clog2(NB);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_DRAIN, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [23:0]    addr_q, addr_d;
  logic [4:0]     beats_q, beats_d;
  logic [4:0]     beats_in_q, beats_in_d;    // beats taken from the write channel
  logic [4:0]     beats_out_q, beats_out_d;  // beats completely sent
  logic [1:0]     hdr_cnt_q, hdr_cnt_d;
  logic [BIW-1:0] byte_idx_q, byte_idx_d;
  logic [DW-1:0]  buf_q, buf_d;              // beat held with strobes already applied
  logic           buf_full_q, buf_full_d;
  logic           err_q, err_d;

  logic [DW-1:0]  wdata_masked;
  logic [DW-1:0]  cur_beat;
  logic [8:0]     page_end;
  logic           cmd_illegal;
  logic           beats_left;
  logic           last_byte;
  logic           final_beat;
  logic           tx_fire;
  logic           w_fire;

  // Disabled bytes become 0xFF before they ever reach the buffer.
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_mask
      assign wdata_masked[gi*8 +: 8] = wstrb[gi] ? wdata[gi*8 +: 8] : 8'hFF;
    end
    if (AW > 24) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^cmd_addr[AW-1:24];
    end
  endgenerate

  // 9 bits is enough: beats above 16 are rejected on their own.
  assign page_end    = {1'b0, cmd_addr[7:0]} + {cmd_beats, 4'b0000};
  assign cmd_illegal = (cmd_beats == 5'd0) || (cmd_beats > 5'd16) || (page_end > 9'd256);

  always_comb begin
    beats_left = (beats_in_q != beats_q);
    last_byte  = (byte_idx_q == BIW'(NB - 1));
    final_beat = (beats_out_q == beats_q - 5'd1);
    // With the buffer empty, byte 0 is taken straight from the write channel
    // so the first data byte follows the header with no bubble; that beat is
    // captured in the same cycle because wready is high whenever the buffer
    // is empty.
    cur_beat   = buf_full_q ? buf_q : wdata_masked;

    cmd_ready  = (state_q == S_IDLE);
    tx_valid   = 1'b0;
    tx_byte    = 8'h00;
    tx_last    = 1'b0;
    wready     = 1'b0;
    done_valid = 1'b0;
    done_err   = 1'b0;

    case (state_q)
      S_HDR: begin
        tx_valid = 1'b1;
        case (hdr_cnt_q)
          2'd0:    tx_byte = 8'h02;
          2'd1:    tx_byte = addr_q[23:16];
          2'd2:    tx_byte = addr_q[15:8];
          default: tx_byte = addr_q[7:0];
        endcase
      end
      S_DATA: begin
        tx_valid = buf_full_q || wvalid;
        tx_byte  = cur_beat[{byte_idx_q, 3'b000} +: 8];
        tx_last  = buf_full_q && last_byte && final_beat;
        // Refill in the same cycle the last byte leaves to keep the stream gap-free.
        wready   = beats_left && (!buf_full_q || (last_byte && tx_ready));
      end
      S_DRAIN: begin
        wready = beats_left;
      end
      S_DONE: begin
        done_valid = 1'b1;
        done_err   = err_q;
      end
      default: ;
    endcase

    tx_fire = tx_valid && tx_ready;
    w_fire  = wvalid && wready;
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    beats_d     = beats_q;
    beats_in_d  = beats_in_q;
    beats_out_d = beats_out_q;
    hdr_cnt_d   = hdr_cnt_q;
    byte_idx_d  = byte_idx_q;
    buf_d       = buf_q;
    buf_full_d  = buf_full_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d      = cmd_addr[23:0];
          beats_d     = cmd_beats;
          beats_in_d  = 5'd0;
          beats_out_d = 5'd0;
          hdr_cnt_d   = 2'd0;
          byte_idx_d  = '0;
          buf_full_d  = 1'b0;
          err_d       = cmd_illegal;
          state_d     = cmd_illegal ? S_DRAIN : S_HDR;
        end
      end
      S_HDR: begin
        if (tx_fire) begin
          hdr_cnt_d = hdr_cnt_q + 2'd1;
          if (hdr_cnt_q == 2'd3) state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (w_fire) begin
          buf_d      = wdata_masked;
          buf_full_d = 1'b1;
          beats_in_d = beats_in_q + 5'd1;
        end
        if (tx_fire) begin
          if (last_byte) begin
            byte_idx_d  = '0;
            beats_out_d = beats_out_q + 5'd1;
            if (!w_fire) buf_full_d = 1'b0;
            if (final_beat) state_d = S_DONE;
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (w_fire) beats_in_d = beats_in_q + 5'd1;
        if (beats_in_d == beats_q) state_d = S_DONE;
      end
      S_DONE: begin
        if (done_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      beats_q     <= '0;
      beats_in_q  <= '0;
      beats_out_q <= '0;
      hdr_cnt_q   <= '0;
      byte_idx_q  <= '0;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      beats_q     <= beats_d;
      beats_in_q  <= beats_in_d;
      beats_out_q <= beats_out_d;
      hdr_cnt_q   <= hdr_cnt_d;
      byte_idx_q  <= byte_idx_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_spi_wr_serializer.sv
// Testbench for spi_wr_serializer: table of directed commands, a mid-burst
// reset sequence and randomized commands, all checked against a byte-level
// reference model of the flash page-program stream.
module tb_spi_wr_serializer;
  localparam int DW = 128;
  localparam int AW = 32;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [4:0]    cmd_beats = '0;
  logic [DW-1:0] wdata = '0;
  logic [15:0]   wstrb = '0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [7:0]    tx_byte;
  logic          tx_valid;
  logic          tx_last;
  logic          tx_ready = 1'b0;
  logic          done_valid;
  logic          done_err;
  logic          done_ready = 1'b0;

  always #5 aclk = ~aclk;

  spi_wr_serializer #(.DW(DW), .AW(AW)) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
    .done_valid(done_valid), .done_err(done_err), .done_ready(done_ready)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Observations gathered at each falling edge.
  logic [7:0] got_b[$];
  logic       got_l[$];
  int         got_c[$];
  int         w_cnt, d_cnt, cmd_cyc;
  logic       d_err;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_byte;
  logic       prev_last;
  logic       w_fire_s, d_fire_s, s_done_wait, s_cmd_ready, s_done_err;

  logic [DW-1:0] beat_data[16];
  logic [15:0]   beat_strb[16];

  typedef struct {
    logic [23:0] addr;
    int          beats;
    int          strb_mode;  // 0 full, 1 = 16'h00F0, 2 random
    int          p_tx;
    int          p_w;
    int          done_hold;
    int          exp_err;
    int          exp_bytes;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: observe at the falling edge, return 1 time unit after the rising edge.
  task automatic step();
    @(negedge aclk);
    cyc++;
    w_fire_s    = 1'b0;
    d_fire_s    = 1'b0;
    s_done_wait = 1'b0;
    s_cmd_ready = cmd_ready;
    s_done_err  = done_err;
    if (!areset) begin
      if (prev_stall) begin
        chk("tx_valid_hold", tx_valid, 1);
        chk("tx_byte_hold", tx_byte, prev_byte);
        chk("tx_last_hold", tx_last, prev_last);
      end
      if (tx_valid && tx_ready) begin
        got_b.push_back(tx_byte);
        got_l.push_back(tx_last);
        got_c.push_back(cyc);
      end
      if (wvalid && wready) begin
        w_cnt++;
        w_fire_s = 1'b1;
      end
      if (done_valid && done_ready) begin
        d_cnt++;
        d_err = done_err;
        d_fire_s = 1'b1;
      end
      s_done_wait = done_valid && !done_ready;
      if (cmd_valid && cmd_ready) cmd_cyc = cyc;
      prev_stall = tx_valid && !tx_ready;
      prev_byte  = tx_byte;
      prev_last  = tx_last;
    end else begin
      prev_stall = 1'b0;
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic fill_beats(input int strb_mode);
    for (int b = 0; b < 16; b++) begin
      beat_data[b] = {$urandom, $urandom, $urandom, $urandom};
      case (strb_mode)
        0:       beat_strb[b] = 16'hFFFF;
        1:       beat_strb[b] = 16'h00F0;
        default: beat_strb[b] = 16'($urandom);
      endcase
    end
  endtask

  task automatic clear_obs();
    got_b.delete();
    got_l.delete();
    got_c.delete();
    w_cnt = 0;
    d_cnt = 0;
    cmd_cyc = -1;
    d_err = 1'b0;
  endtask

  task automatic run_cmd(input logic [23:0] addr, input int beats, input int strb_mode,
                         input int p_tx, input int p_w, input int done_hold,
                         input int tab_err, input int tab_bytes, input string tag);
    logic [7:0]    exp_b[$];
    logic          exp_l[$];
    logic          exp_err;
    logic [DW-1:0] d;
    logic [15:0]   s;
    int            lo, wi, held, n, m;
    logic          w_hold, fin;

    fill_beats(strb_mode);
    // Reference model: what a page-program of this command must look like.
    lo = int'(addr[7:0]);
    exp_err = (beats == 0) || (beats > 16) || (lo + beats * 16 > 256);
    exp_b.delete();
    exp_l.delete();
    if (!exp_err) begin
      exp_b.push_back(8'h02);
      exp_b.push_back(addr[23:16]);
      exp_b.push_back(addr[15:8]);
      exp_b.push_back(addr[7:0]);
      for (int k = 0; k < 4; k++) exp_l.push_back(1'b0);
      for (int b = 0; b < beats; b++) begin
        d = beat_data[b];
        s = beat_strb[b];
        for (int i = 0; i < 16; i++) begin
          exp_b.push_back(s[i] ? d[i*8 +: 8] : 8'hFF);
          exp_l.push_back((b == beats - 1) && (i == 15));
        end
      end
    end

    clear_obs();
    cmd_valid = 1'b1;
    cmd_addr  = {8'h5A, addr};
    cmd_beats = beats[4:0];
    chk({tag, " cmd_ready_idle"}, cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    cmd_addr  = AW'($urandom);
    wi = 0;
    held = 0;
    n = 0;
    w_hold = 1'b0;
    fin = 1'b0;
    while (!fin && n < 3000) begin
      if (wi < beats && (w_hold || $urandom_range(99) < p_w)) begin
        wvalid = 1'b1;
        wdata  = beat_data[wi % 16];
        wstrb  = beat_strb[wi % 16];
      end else begin
        wvalid = 1'b0;
        wdata  = {$urandom, $urandom, $urandom, $urandom};
        wstrb  = 16'($urandom);
      end
      tx_ready   = ($urandom_range(99) < p_tx);
      done_ready = (held >= done_hold);
      step();
      if (w_fire_s) wi++;
      w_hold = wvalid && !w_fire_s;
      if (s_done_wait) begin
        held++;
        chk({tag, " cmd_ready_in_done"}, s_cmd_ready, 0);
        chk({tag, " done_err_hold"}, s_done_err, exp_err);
      end
      if (d_fire_s) fin = 1'b1;
      n++;
    end
    wvalid = 1'b0;
    tx_ready = 1'b0;
    done_ready = 1'b0;
    chk({tag, " done_seen"}, fin, 1);
    if (!fin) begin
      areset = 1'b1;
      step();
      areset = 1'b0;
    end else begin
      chk({tag, " idle_after_done"}, cmd_ready, 1);
      chk({tag, " done_valid_cleared"}, done_valid, 0);
    end

    chk({tag, " done_count"}, d_cnt, 1);
    chk({tag, " done_err"}, d_err, exp_err);
    chk({tag, " wbeats"}, w_cnt, beats);
    chk({tag, " nbytes"}, got_b.size(), exp_b.size());
    if (tab_err >= 0) chk({tag, " table_err"}, d_err, tab_err);
    if (tab_bytes >= 0) chk({tag, " table_bytes"}, got_b.size(), tab_bytes);
    m = (got_b.size() < exp_b.size()) ? got_b.size() : exp_b.size();
    for (int i = 0; i < m; i++) begin
      chk($sformatf("%s byte%0d", tag, i), got_b[i], exp_b[i]);
      chk($sformatf("%s last%0d", tag, i), got_l[i], exp_l[i]);
    end
    if (!exp_err && p_tx == 100 && got_c.size() > 0)
      chk({tag, " first_hdr_latency"}, got_c[0] - cmd_cyc, 1);
    if (!exp_err && p_tx == 100 && p_w == 100 && got_c.size() > 0)
      chk({tag, " gap_free"}, got_c[got_c.size()-1] - got_c[0], got_c.size() - 1);
    $display("cmd %s addr=%06h beats=%0d err=%0d bytes=%0d wbeats=%0d", tag, addr, beats,
             d_err, got_b.size(), w_cnt);
  endtask

  initial begin
    int nb, nw, n, wi, beats, lo;
    vecs[0]  = '{24'h012300, 2,  0, 100, 100, 0, 0, 36};
    vecs[1]  = '{24'h000010, 1,  1, 100, 100, 0, 0, 20};
    vecs[2]  = '{24'h0000F8, 1,  0, 100, 100, 0, 1, 0};
    vecs[3]  = '{24'h0000F8, 0,  0, 100, 100, 0, 1, 0};
    vecs[4]  = '{24'h000000, 17, 0, 100, 70,  0, 1, 0};
    vecs[5]  = '{24'h0000F0, 1,  0, 50,  50,  1, 0, 20};
    vecs[6]  = '{24'h0000F1, 1,  0, 100, 100, 0, 1, 0};
    vecs[7]  = '{24'hAB0000, 16, 2, 60,  60,  3, 0, 260};
    vecs[8]  = '{24'h000080, 8,  2, 100, 100, 0, 0, 132};
    vecs[9]  = '{24'h000090, 8,  0, 70,  70,  5, 1, 0};
    vecs[10] = '{24'h345600, 1,  0, 100, 100, 5, 0, 20};
    vecs[11] = '{24'h000000, 31, 0, 80,  80,  0, 1, 0};

    // Reset and post-reset output values.
    clear_obs();
    areset = 1'b1;
    repeat (3) step();
    areset = 1'b0;
    chk("rst cmd_ready", cmd_ready, 1);
    chk("rst tx_valid", tx_valid, 0);
    chk("rst tx_last", tx_last, 0);
    chk("rst tx_byte", tx_byte, 0);
    chk("rst wready", wready, 0);
    chk("rst done_valid", done_valid, 0);
    chk("rst done_err", done_err, 0);
    $display("reset released: cmd_ready=%0d tx_valid=%0d", cmd_ready, tx_valid);

    foreach (vecs[i])
      run_cmd(vecs[i].addr, vecs[i].beats, vecs[i].strb_mode, vecs[i].p_tx, vecs[i].p_w,
              vecs[i].done_hold, vecs[i].exp_err, vecs[i].exp_bytes, $sformatf("vec%0d", i));

    // Reset after 10 data bytes of a 2-beat command.
    fill_beats(0);
    clear_obs();
    cmd_valid = 1'b1;
    cmd_addr  = 32'h0000_0000;
    cmd_beats = 5'd2;
    step();
    cmd_valid = 1'b0;
    tx_ready = 1'b1;
    n = 0;
    wi = 0;
    while (got_b.size() < 14 && n < 200) begin
      wvalid = (wi < 2);
      wdata  = beat_data[wi % 16];
      wstrb  = 16'hFFFF;
      step();
      if (w_fire_s) wi++;
      n++;
    end
    chk("midrst reached_10_data", got_b.size(), 14);
    areset = 1'b1;
    step();
    areset = 1'b0;
    chk("midrst tx_valid", tx_valid, 0);
    chk("midrst done_valid", done_valid, 0);
    chk("midrst cmd_ready", cmd_ready, 1);
    chk("midrst wready", wready, 0);
    chk("midrst tx_last", tx_last, 0);
    nb = got_b.size();
    nw = w_cnt;
    wvalid = 1'b1;
    repeat (6) step();
    chk("midrst no_more_bytes", got_b.size(), nb);
    chk("midrst no_more_beats", w_cnt, nw);
    chk("midrst no_done", d_cnt, 0);
    wvalid = 1'b0;
    tx_ready = 1'b0;
    $display("mid-burst reset: bytes=%0d beats=%0d", nb, nw);
    run_cmd(24'h012300, 2, 0, 100, 100, 0, 0, 36, "after_rst");

    // Randomized commands, mostly legal.
    for (int r = 0; r < 25; r++) begin
      if ($urandom_range(3) != 0) begin
        beats = $urandom_range(16, 1);
        lo = $urandom_range(256 - beats * 16, 0);
      end else begin
        beats = $urandom_range(20, 0);
        lo = $urandom_range(255, 0);
      end
      run_cmd({16'($urandom), lo[7:0]}, beats, 2, $urandom_range(100, 30),
              $urandom_range(100, 30), $urandom_range(3, 0), -1, -1, $sformatf("rnd%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_wr_serializer.md
SPI_WR_SERIALIZER -- requirements
Module: spi_wr_serializer

Interface
REQ-001 SHALL have parameter DW, default 128, meaning write-data beat width in bits (16 bytes per beat).
REQ-002 SHALL have parameter AW, default 32, meaning command address width; only addr[23:0] is used.
REQ-003 SHALL have port aclk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port areset, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_addr in AW, cmd_beats in 5: page-program command request, beat count 1..16.
REQ-006 SHALL have ports wdata in DW, wstrb in DW/8, wvalid in 1, wready out 1: write-data beats from the AXI write slave.
REQ-007 SHALL have ports tx_byte out 8, tx_valid out 1, tx_last out 1, tx_ready in 1: byte stream to the QSPI shifter.
REQ-008 SHALL have ports done_valid out 1, done_err out 1, done_ready in 1: completion status returned to the AXI write slave for its B response.

Function
REQ-009 SHALL implement states IDLE, HDR, DATA, DRAIN, DONE.
REQ-010 IDLE: cmd_ready=1; on cmd_valid&&cmd_ready, latch addr[23:0] and beats, then go to HDR, or to DRAIN if the command is illegal.
REQ-011 A command SHALL be illegal when cmd_beats==0, cmd_beats>16, or addr[7:0]+cmd_beats*16>256 (page crossing), using 9-bit arithmetic.
REQ-012 HDR: SHALL emit 4 bytes, one per tx handshake: 0x02, addr[23:16], addr[15:8], addr[7:0]; then go to DATA.
REQ-013 DATA: SHALL emit each beat as 16 bytes, byte 0 (wdata[7:0]) first.
REQ-014 A byte whose wstrb bit is 0 SHALL be emitted as 0xFF, which leaves flash unchanged.
REQ-015 tx_last SHALL be 1 only on the final data byte of the command; after that handshake, go to DONE.
REQ-016 A single-entry beat buffer SHALL hold the current beat; wready=1 in DATA when the buffer is empty, or when the buffer's byte 15 handshakes this cycle and more beats remain.
REQ-017 With tx_ready held high and wvalid high, the stream SHALL be gap-free: one byte per cycle across beat boundaries.
REQ-018 The buffer SHALL accept no more beats than cmd_beats.
REQ-019 The first HDR byte SHALL appear (tx_valid=1) the cycle after the command handshake.
REQ-020 DRAIN: wready=1 and tx_valid=0; SHALL accept exactly cmd_beats beats (none if cmd_beats==0) and discard them, then go to DONE with the error flag set.
REQ-021 DONE: done_valid=1 and done_err equals the latched error flag; on done_ready, return to IDLE.
REQ-022 A new command SHALL be accepted no earlier than the cycle after done handshakes.
REQ-023 Outputs SHALL hold stable while valid and not ready: tx_byte/tx_last while tx_valid&&!tx_ready; done_err while done_valid&&!done_ready.
REQ-024 wready SHALL be 0 in IDLE, HDR and DONE.

Reset
REQ-025 While areset=1 at a clock edge, the block SHALL return to IDLE, clear the buffer, the counters and the error flag, and abandon any command in flight.
REQ-026 After reset, outputs SHALL be: cmd_ready=1 (from the first cycle after reset deasserts), tx_valid=0, tx_last=0, tx_byte=0, wready=0, done_valid=0, done_err=0.
REQ-027 Reset asserted mid-burst SHALL cause no further bytes, beats or done pulses for the abandoned command.

Verification
REQ-028 Happy path: addr=0x012300, beats=2, full strobes, tx_ready=1 -> bytes 02 01 23 00 then 32 data bytes in 36 consecutive cycles; tx_last on byte 36; done_err=0.
REQ-029 Strobe mask: beats=1, wstrb=0x00F0 -> bytes 4..7 carry data; the other 12 data bytes are 0xFF.
REQ-030 Page cross: addr=0x0000F8, beats=1 -> no tx bytes, exactly 1 beat drained, done_err=1; repeat with beats=0 -> 0 beats drained, done_err=1.
REQ-031 Backpressure: random tx_ready and wvalid with beats=16, addr low byte=0x00 -> byte order intact, tx_byte/tx_last stable while stalled, exactly 16 wready handshakes.
REQ-032 Reset mid-operation: areset pulsed after 10 data bytes -> next cycle tx_valid=0, done_valid=0, cmd_ready=1; a following command runs normally.
REQ-033 Done backpressure: done_ready=0 for 5 cycles -> done_valid held and cmd_ready=0 throughout; IDLE one cycle after the done handshake.
